// File: rtl/snake_pkg.sv
// Shared types for the snake game controller: headings, game states and the
// turn-validity helper.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DEAD  = 2'd2,
    PAUSE = 2'd3
  } game_state_t;

  localparam int TURN_DEPTH = 2;

  // Opposite headings share the upper bit and differ only in the lower one.
  function automatic logic is_opposite(dir_t a, dir_t b);
    return (2'(a) ^ 2'(b)) == 2'b01;
  endfunction

endpackage

// File: rtl/snake_turn_fifo.sv
// Two-entry queue of pending turns; head feeds the heading on the next move
// tick, tail is the reference for filtering newly pressed turns.
module snake_turn_fifo
  import snake_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  dir_t din_i,
  input  logic pop_i,
  input  logic flush_i,
  output dir_t head_o,
  output dir_t tail_o,
  output logic empty_o,
  output logic full_o
);

  dir_t       mem_q [TURN_DEPTH];
  logic       rd_q, wr_q;
  logic [1:0] cnt_q;
  logic       do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
      mem_q[0] <= DIR_UP;
      mem_q[1] <= DIR_UP;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_o  = mem_q[rd_q];
  assign tail_o  = mem_q[~wr_q];
  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: button edges -> filtered turn queue, move tick,
// IDLE/RUN/DEAD state machine and saturating score. SNAKE_PAUSE_EN adds PAUSE.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_SLOW = 16777216,
  parameter int TICK_FAST = 8388608,
  parameter int MAX_LEN   = 25,
  parameter int TICK_W    = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        speed,
  input  logic        pause,
  input  logic        collide,
  input  logic        eat,
  output logic        move,
  output logic [1:0]  dir,
  output logic        grow,
  output logic        running,
  output logic        lose,
  output logic [15:0] score
);

`ifdef SNAKE_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  localparam logic [TICK_W-1:0] LIM_SLOW  = TICK_W'(TICK_SLOW - 1);
  localparam logic [TICK_W-1:0] LIM_FAST  = TICK_W'(TICK_FAST - 1);
  localparam logic [15:0]       MAX_SCORE = 16'(MAX_LEN);

  game_state_t       state_q, state_d;
  logic [TICK_W-1:0] cnt_q, cnt_d, limit;
  dir_t              dir_q, dir_d;
  logic              move_q, move_d, grow_q, grow_d;
  logic [15:0]       score_q, score_d;
  logic [3:0]        btn, btn_q, btn_edge;
  logic              pause_q, pause_edge;
  logic              press_vld, accept;
  dir_t              press_dir, ref_dir, fifo_head, fifo_tail;
  logic              fifo_empty, fifo_full, push, pop, flush;

  // Bit index matches the dir_t encoding.
  assign btn        = {right, left, down, up};
  assign btn_edge   = btn & ~btn_q;
  assign press_vld  = |btn_edge;
  assign pause_edge = PAUSE_EN & pause & ~pause_q;
  assign limit      = speed ? LIM_FAST : LIM_SLOW;

  always_comb begin
    if      (btn_edge[0]) press_dir = DIR_UP;
    else if (btn_edge[1]) press_dir = DIR_DOWN;
    else if (btn_edge[2]) press_dir = DIR_LEFT;
    else                  press_dir = DIR_RIGHT;
  end

  // Turns are judged against the last queued heading so two quick presses
  // cannot combine into a reversal.
  assign ref_dir = fifo_empty ? dir_q : fifo_tail;
  assign accept  = press_vld && !fifo_full && (press_dir != ref_dir) &&
                   !is_opposite(press_dir, ref_dir);

  snake_turn_fifo u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (press_dir),
    .pop_i   (pop),
    .flush_i (flush),
    .head_o  (fifo_head),
    .tail_o  (fifo_tail),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    score_d = score_q;
    move_d  = 1'b0;
    grow_d  = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_vld) begin
          dir_d   = press_dir;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (collide) begin
          state_d = DEAD;
          flush   = 1'b1;
        end else if (pause_edge) begin
          state_d = PAUSE;
        end else begin
          push = accept;
          if (cnt_q >= limit) begin
            cnt_d  = '0;
            move_d = 1'b1;
            if (!fifo_empty) begin
              pop   = 1'b1;
              dir_d = fifo_head;
            end
          end else begin
            cnt_d = cnt_q + TICK_W'(1);
          end
          if (eat && (score_q != MAX_SCORE)) begin
            score_d = score_q + 16'd1;
            grow_d  = 1'b1;
          end
        end
      end
      DEAD: ;
      PAUSE: begin
`ifdef SNAKE_PAUSE_EN
        if (pause_edge) state_d = RUN;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_UP;
      score_q <= 16'd0;
      move_q  <= 1'b0;
      grow_q  <= 1'b0;
      btn_q   <= 4'd0;
      pause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      score_q <= score_d;
      move_q  <= move_d;
      grow_q  <= grow_d;
      btn_q   <= btn;
      pause_q <= pause;
    end
  end

  assign move    = move_q;
  assign grow    = grow_q;
  assign dir     = 2'(dir_q);
  assign score   = score_q;
  assign running = (state_q == RUN);
  assign lose    = (state_q == DEAD);

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed plus randomized bench for snake_game_ctrl against a queue-based
// behavioural model of the game rules.
module tb_snake_game_ctrl;

  localparam int SLOW = 8;
  localparam int FAST = 4;
  localparam int MAXL = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_DEAD = 2, M_PAUSE = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic speed = 1'b0, pause = 1'b0, collide = 1'b0, eat = 1'b0;
  logic move, grow, running, lose;
  logic [1:0]  dir;
  logic [15:0] score;

  int vectors = 0;
  int miscompares = 0;

  int     m_state = M_IDLE;
  int     m_dir = 0, m_cnt = 0, m_score = 0;
  bit     m_move = 1'b0, m_grow = 1'b0;
  bit [3:0] m_prev = 4'd0;
  bit     m_ppause = 1'b0;
  int     q[$];

  snake_game_ctrl #(
    .TICK_SLOW (SLOW),
    .TICK_FAST (FAST),
    .MAX_LEN   (MAXL),
    .TICK_W    (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .up      (up),
    .down    (down),
    .left    (left),
    .right   (right),
    .speed   (speed),
    .pause   (pause),
    .collide (collide),
    .eat     (eat),
    .move    (move),
    .dir     (dir),
    .grow    (grow),
    .running (running),
    .lose    (lose),
    .score   (score)
  );

  always #5 clk = ~clk;

  // One clock edge of the game rules, applied to the inputs seen at the edge.
  task automatic model_edge();
    bit [3:0] b, e;
    int p, refd, per;
    bit pe, take;
    b = {right, left, down, up};
    if (reset) begin
      m_state = M_IDLE; m_dir = 0; m_cnt = 0; m_score = 0;
      m_move = 1'b0; m_grow = 1'b0; m_prev = 4'd0; m_ppause = 1'b0;
      q.delete();
      return;
    end
    e = b & ~m_prev;
    p = -1;
    for (int i = 3; i >= 0; i--) if (e[i]) p = i;
    pe = pause && !m_ppause;
`ifndef SNAKE_PAUSE_EN
    pe = 1'b0;
`endif
    m_prev = b; m_ppause = pause;
    m_move = 1'b0; m_grow = 1'b0;
    case (m_state)
      M_IDLE: if (p >= 0) begin m_dir = p; m_cnt = 0; m_state = M_RUN; end
      M_RUN: begin
        if (collide) begin
          m_state = M_DEAD; q.delete();
        end else if (pe) begin
          m_state = M_PAUSE;
        end else begin
          refd = (q.size() > 0) ? q[$] : m_dir;
          // a valid turn changes axis: up/down share one axis, left/right the other
          take = (p >= 0) && (p / 2 != refd / 2) && (q.size() < 2);
          per = speed ? FAST : SLOW;
          if (m_cnt >= per - 1) begin
            m_cnt = 0; m_move = 1'b1;
            if (q.size() > 0) m_dir = q.pop_front();
          end else begin
            m_cnt++;
          end
          if (take) q.push_back(p);
          if (eat && m_score < MAXL) begin m_score++; m_grow = 1'b1; end
        end
      end
      M_PAUSE: if (pe) m_state = M_RUN;
      default: ;
    endcase
  endtask

  task automatic tick();
    logic [21:0] obs, exp;
    @(posedge clk);
    model_edge();
    #1;
    obs = {move, dir, grow, running, lose, score};
    exp = {m_move, 2'(m_dir), m_grow, m_state == M_RUN, m_state == M_DEAD, 16'(m_score)};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL cycle_model: observed %h expected %h", obs, exp);
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_move(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (move) begin n = i; break; end
    end
  endtask

  initial begin
    int n, grows, moves;

    // reset state
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    chk("reset_outs", int'({move, grow, running, lose, dir, score}), 0);

    // start and tick periods
    right = 1'b1; tick(); right = 1'b0;
    chk("start_running", int'(running), 1);
    chk("start_dir", int'(dir), 3);
    wait_move(n); chk("first_move", n, 8);
    wait_move(n); chk("period_slow", n, 8);
    speed = 1'b1;
    wait_move(n); chk("period_fast", n, 4);

    // reversal dropped, two queued turns, third press dropped while full
    left = 1'b1; tick();
    left = 1'b0; up = 1'b1; tick();
    up = 1'b0; left = 1'b1; tick();
    left = 1'b0; down = 1'b1; tick();
    down = 1'b0;
    chk("turn1_move", int'(move), 1);
    chk("turn1_dir", int'(dir), 0);
    wait_move(n); chk("turn2_period", n, 4);
    chk("turn2_dir", int'(dir), 2);
    wait_move(n); chk("full_drop_dir", int'(dir), 2);

    // score saturation
    grows = 0;
    for (int k = 1; k <= 4; k++) begin
      eat = 1'b1; tick(); if (grow) grows++;
      eat = 1'b0;
      chk("score_step", int'(score), (k < MAXL) ? k : MAXL);
      tick(); if (grow) grows++;
    end
    chk("grow_count", grows, 3);

    // collide beats eat; DEAD ignores everything
    collide = 1'b1; eat = 1'b1; tick(); collide = 1'b0; eat = 1'b0;
    chk("lose", int'(lose), 1);
    chk("score_hold", int'(score), 3);
    moves = 0;
    for (int i = 0; i < 12; i++) begin
      up = (i % 2 == 0); down = (i % 3 == 0); eat = (i % 4 == 0);
      tick(); if (move) moves++;
    end
    up = 1'b0; down = 1'b0; eat = 1'b0;
    chk("dead_moves", moves, 0);
    chk("dead_dir", int'(dir), 2);

    // reset from DEAD, then reset in RUN with a queued turn
    reset = 1'b1; tick(); reset = 1'b0;
    chk("reset_dead", int'({move, grow, running, lose, dir, score}), 0);
    right = 1'b1; tick(); right = 1'b0; tick();
    up = 1'b1; tick(); up = 1'b0; tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("reset_run", int'({move, grow, running, lose, dir, score}), 0);
    right = 1'b1; tick(); right = 1'b0;
    wait_move(n); chk("reset_flush_period", n, 4);
    chk("reset_flush_dir", int'(dir), 3);

    // pause
    speed = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    right = 1'b1; tick(); right = 1'b0;
    repeat (5) tick();
    pause = 1'b1; tick(); pause = 1'b0;
`ifdef SNAKE_PAUSE_EN
    moves = 0;
    for (int i = 0; i < 12; i++) begin
      up = (i == 3); collide = (i == 6); eat = (i == 8);
      tick(); if (move) moves++;
    end
    up = 1'b0; collide = 1'b0; eat = 1'b0;
    chk("pause_moves", moves, 0);
    chk("pause_running", int'(running), 0);
    pause = 1'b1; tick(); pause = 1'b0;
    chk("resume_running", int'(running), 1);
    wait_move(n); chk("resume_move", n, 3);
    chk("resume_dir", int'(dir), 3);
`else
    wait_move(n); chk("pause_ignored", n, 2);
    wait_move(n); chk("pause_ignored_period", n, 8);
`endif

    // randomized play
    for (int i = 0; i < 3000; i++) begin
      up      = ($urandom_range(0, 5) == 0);
      down    = ($urandom_range(0, 5) == 0);
      left    = ($urandom_range(0, 5) == 0);
      right   = ($urandom_range(0, 5) == 0);
      pause   = ($urandom_range(0, 15) == 0);
      eat     = ($urandom_range(0, 9) == 0);
      collide = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 31) == 0) speed = ~speed;
      reset   = ((m_state == M_DEAD) && ($urandom_range(0, 9) == 0)) ||
                ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
